// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and latches
// the returned word into the IF/ID register, with stall, redirect and halt.
module instruction_fetch #(
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [31:0] HALT_WORD = 32'h0000000C
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_start,
    input  logic        IF_stall,
    input  logic        IF_redirect,
    input  logic [7:0]  IF_redirect_target,
    output logic [7:0]  IMEM_PC,
    input  logic [31:0] IMEM_instruction,
    output logic [7:0]  ID_pc,
    output logic [31:0] ID_instruction,
    output logic        ID_valid,
    output logic        IF_halted,
    output logic        IF_misalign,
    output logic [15:0] IF_fetch_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic       fetch;
    logic       is_halt_word;

    assign IMEM_PC      = pc;
    assign IF_halted    = (state == HALT);
    assign is_halt_word = (IMEM_instruction == HALT_WORD);

    // A fetch latches IMEM into IF/ID; redirect outranks stall, which outranks fetch.
    assign fetch = (state == RUN) && !IF_redirect && !IF_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (IF_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (fetch && is_halt_word) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (IF_redirect) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            ID_pc          <= '0;
            ID_instruction <= '0;
            ID_valid       <= 1'b0;
            IF_misalign    <= 1'b0;
            IF_fetch_count <= '0;
        end else begin
            IF_misalign <= IF_redirect && (IF_redirect_target[1:0] != 2'b00);
            if (IF_redirect) begin
                pc       <= IF_redirect_target & 8'hFC;
                ID_valid <= 1'b0;
            end else if (fetch) begin
                ID_pc          <= pc;
                ID_instruction <= IMEM_instruction;
                ID_valid       <= 1'b1;
                if (!is_halt_word) begin
                    pc <= pc + 8'd4;
                end
                if (IF_fetch_count != '1) begin
                    IF_fetch_count <= IF_fetch_count + 16'd1;
                end
            end else if (state == HALT && !IF_stall) begin
                // Halt word drains out of IF/ID once decode accepts it.
                ID_valid <= 1'b0;
            end
        end
    end

endmodule
